// File: rtl/uart_line_rx.sv
// 8N1 UART receiver with a newline-terminated line buffer.
// Completed lines are held under a valid/ack handshake.
module uart_line_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int MAX_LEN  = 53
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic [7:0] line [0:MAX_LEN-1],
  output logic [7:0] line_len,
  output logic       line_valid,
  input  logic       line_ack,
  output logic       line_trunc,
  output logic       rx_overrun
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;

  // Counters reload with N-1 so the sample lands exactly N edges later.
  localparam logic [8:0] CPB_LD  = 9'(CPB - 1);
  localparam logic [8:0] HALF_LD = 9'(HALF - 1);
  localparam logic [7:0] MAX_L   = 8'(MAX_LEN);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0] sync;
  logic       rxs;
  logic       rxs_q;
  logic [2:0] state;
  logic [8:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] fill;
  logic       trunc;
  logic       is_cr;
  logic       is_lf;

  assign rxs   = sync[1];
  assign rxs_q = sync[2];
  assign is_cr = (rx_byte == CH_CR);
  assign is_lf = (rx_byte == CH_LF);

  // Synchroniser resets to idle-high so reset release is not a start edge.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b111;
    end else begin
      sync <= {sync[1:0], rxd};
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (cnt != 9'd0) cnt <= cnt - 9'd1;
      unique case (state)
        S_IDLE: begin
          if (rxs_q && !rxs) begin
            cnt   <= HALF_LD;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == 9'd0) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              cnt     <= CPB_LD;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (cnt == 9'd0) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= CPB_LD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (cnt == 9'd0) begin
            if (rxs) begin
              rx_byte       <= shreg;
              rx_byte_valid <= 1'b1;
              state         <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A byte arriving on the ack edge is still dropped so the frozen
  // buffer never mixes with the next line.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) line[i] <= '0;
      line_len   <= '0;
      line_valid <= 1'b0;
      line_trunc <= 1'b0;
      rx_overrun <= 1'b0;
      fill       <= '0;
      trunc      <= 1'b0;
    end else begin
      if (line_valid && line_ack) begin
        line_valid <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (rx_byte_valid) begin
        if (line_valid) begin
          rx_overrun <= 1'b1;
        end else if (is_lf) begin
          if (fill != 8'd0) begin
            line_len   <= fill;
            line_valid <= 1'b1;
            line_trunc <= trunc;
            fill       <= '0;
            trunc      <= 1'b0;
          end
        end else if (!is_cr) begin
          if (fill < MAX_L) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (fill == 8'(i)) line[i] <= rx_byte;
            end
            fill <= fill + 8'd1;
          end else begin
            trunc <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: directed frames, queued
// expectations, monitors compare bytes and lines as they appear.
module tb_uart_line_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int MAX_LEN  = 53;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rxd     = 1'b1;
  logic       line_ack = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic [7:0] line [0:MAX_LEN-1];
  logic [7:0] line_len;
  logic       line_valid;
  logic       line_trunc;
  logic       rx_overrun;

  uart_line_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk_50M(clk_50M),
    .rst_n(rst_n),
    .rxd(rxd),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err(frame_err),
    .line(line),
    .line_len(line_len),
    .line_valid(line_valid),
    .line_ack(line_ack),
    .line_trunc(line_trunc),
    .rx_overrun(rx_overrun)
  );

  always #10 clk_50M = ~clk_50M;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_bytes [$];
  int         exp_len   [$];
  logic       exp_trunc [$];
  logic [7:0] exp_chr   [$];

  int fe_cnt   = 0;
  bit auto_ack = 1'b1;
  int ack_req  = 0;
  int ack_seen = 0;
  bit lv_q     = 1'b0;
  bit acked    = 1'b0;
  int hold     = 0;
  int n_exp    = 0;
  int bad      = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk_50M);
    end
    rxd = 1'b1;
    repeat (CPB) @(negedge clk_50M);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic exp_line(input string s, input logic tr);
    exp_len.push_back(s.len());
    exp_trunc.push_back(tr);
    for (int i = 0; i < s.len(); i++) exp_chr.push_back(s[i]);
  endtask

  task automatic drain(input string name);
    repeat (2 * CPB) @(negedge clk_50M);
    check({name, "_bytes_left"}, exp_bytes.size(), 0);
    check({name, "_lines_left"}, exp_len.size(), 0);
  endtask

  task automatic check_reset(input string name);
    int nz;
    nz = 0;
    check({name, "_outs"}, {rx_byte, rx_byte_valid, frame_err, line_len,
           line_valid, line_trunc, rx_overrun}, 0);
    for (int i = 0; i < MAX_LEN; i++) if (line[i] !== 8'h00) nz++;
    check({name, "_line_nonzero"}, nz, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk_50M);
      if (rx_byte_valid) begin
        if (exp_bytes.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_byte: unexpected byte %02h", rx_byte);
        end else begin
          check("rx_byte", rx_byte, exp_bytes.pop_front());
        end
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk_50M);
      line_ack = 1'b0;
      if (acked) begin
        check("line_valid_after_ack", line_valid, 0);
        check("overrun_after_ack", rx_overrun, 0);
        acked = 1'b0;
      end
      if (line_valid && !lv_q) begin
        hold = 0;
        if (exp_len.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL line: unexpected line len %0d", line_len);
        end else begin
          n_exp = exp_len.pop_front();
          check("line_len", line_len, n_exp);
          check("line_trunc", line_trunc, exp_trunc.pop_front());
          bad = 0;
          for (int i = 0; i < n_exp; i++) begin
            if (exp_chr.size() > 0 && line[i] !== exp_chr.pop_front())
              bad++;
          end
          check("line_data_bad", bad, 0);
        end
      end
      if (line_valid) begin
        hold++;
        if ((auto_ack && hold == 4) || ack_req != ack_seen) begin
          line_ack = 1'b1;
          ack_seen = ack_req;
          acked = 1'b1;
        end
      end
      lv_q = line_valid;
    end
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    string s;
    int fe0;
    repeat (5) @(negedge clk_50M);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_50M);

    exp_line("LS", 1'b0);
    send_str("LS\n");
    drain("ls");

    exp_line("A", 1'b0);
    send_str("A\r\n\n");
    drain("crlf");

    s = "";
    for (int i = 0; i < MAX_LEN; i++) s = {s, "x"};
    exp_line(s, 1'b1);
    for (int i = 0; i < 60; i++) send_byte("x");
    send_byte(8'h0A);
    drain("trunc");

    exp_line("B", 1'b0);
    send_str("B\n");
    drain("after_trunc");

    auto_ack = 1'b0;
    exp_line("C", 1'b0);
    send_str("C\nD\n");
    repeat (CPB) @(negedge clk_50M);
    check("ovr_line_valid", line_valid, 1);
    check("ovr_rx_overrun", rx_overrun, 1);
    check("ovr_line_len", line_len, 1);
    check("ovr_line0", line[0], 8'h43);
    ack_req++;
    repeat (10) @(negedge clk_50M);
    auto_ack = 1'b1;
    drain("overrun");

    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (20 * CPB) @(negedge clk_50M);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk_50M);
    check("break_frame_err", fe_cnt - fe0, 1);
    exp_line("E", 1'b0);
    send_str("E\n");
    drain("break");

    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (10) @(negedge clk_50M);
    rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk_50M);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    exp_line("G", 1'b0);
    send_str("G\n");
    drain("glitch");

    send_byte("Z");
    rxd = 1'b0;
    repeat (CPB) @(negedge clk_50M);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk_50M);
    rst_n = 1'b0;
    @(negedge clk_50M);
    check_reset("midreset");
    repeat (5) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_50M);
    exp_line("F", 1'b0);
    send_str("F\n");
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
